key_reset_conditioner: RTL and testbench
========================================

// Module: key_reset_conditioner
// PURPOSE
//   Conditions the raw board push-button (active-low, bouncy, asynchronous) into clean signals.
//   Outputs: a debounced level, one-cycle press/release strobes, and a stretched active-low
//   system reset (ownSysRst).
//   Sits directly upstream of the clock divider / memory / CPU reset net, replacing the raw key-as-reset wiring.
// PARAMETERS
//   pCntWidth         24           width of debounce/stretch counters
//   pDebounceCycles   24'd240000   cycles the synced key must be stable before accepted (10 ms @ 24 MHz); >= 1
//   pResetStretch     24'd16       cycles ownSysRst stays low after release / after iwRst deassertion; >= 1
//   pLongPressCycles  32'd48000000 held cycles before long-press strobe (2 s @ 24 MHz); only with KEY_LONG_PRESS_EN
// PORTS
//   iwClk        in   1  system clock (24 MHz board clock)
//   iwRst        in   1  asynchronous, active-high reset
//   iwnKey       in   1  raw key, active-low, asynchronous to iwClk
//   owKeyLevel   out  1  debounced key state, 1 = pressed
//   owPress      out  1  one-cycle strobe on accepted press
//   owRelease    out  1  one-cycle strobe on accepted release
//   ownSysRst    out  1  active-low reset for downstream logic
//   owLongPress  out  1  one-cycle long-press strobe (port exists only with KEY_LONG_PRESS_EN)
// BEHAVIOUR
//   Reset: 2-FF synchronizer flops = 1 (released); FSM = IDLE; counters = 0; owKeyLevel/owPress/owRelease/owLongPress = 0; ownSysRst = 0.
//   Key sample: wKeySync = ~(2nd sync flop), so 1 = pressed; 2-cycle synchronizer latency.
//   FSM states:
//     IDLE   : released. wKeySync=1 -> PWAIT, cnt=0.
//     PWAIT  : wKeySync=0 -> IDLE (bounce, cnt cleared).
//              else cnt++; at cnt==pDebounceCycles-1 -> HELD, owPress=1 for 1 cycle.
//     HELD   : owKeyLevel=1. wKeySync=0 -> RWAIT, cnt=0.
//     RWAIT  : wKeySync=1 -> HELD (bounce, cnt cleared).
//              else cnt++; at cnt==pDebounceCycles-1 -> IDLE, owRelease=1 for 1 cycle.
//   owKeyLevel: 1 in HELD and RWAIT, 0 in IDLE and PWAIT; registered.
//   Latency: clean key edge -> strobe = 2 (sync) + pDebounceCycles cycles.
//   Bounce: any mismatch during a WAIT state restarts the full debounce window; no partial credit.
//   Reset stretch:
//     ownSysRst driven 0 while FSM is in HELD/RWAIT.
//     On the owRelease cycle, stretch counter loads pResetStretch; ownSysRst stays 0 until it reaches 0, then goes 1.
//     Same stretch applies after iwRst deasserts.
//   Press during stretch: ownSysRst stays 0; stretch counter cleared on entry to HELD.
//   Counters saturate; never wrap.
//   iwRst asserted mid-operation: all state returns to reset values immediately (async); no strobes emitted.
// CONFIGURATION
//   KEY_LONG_PRESS_EN defined:
//     32-bit hold counter runs in HELD (not in RWAIT, not cleared by RWAIT bounce).
//     owLongPress pulses once when count reaches pLongPressCycles-1; saturates, no repeat until the next press.
//   KEY_LONG_PRESS_EN undefined: hold counter, owLongPress port and pLongPressCycles logic are absent.
// STRUCTURE
//   Shared package key_pkg: FSM state encoding (IDLE=2'd0, PWAIT=2'd1, HELD=2'd2, RWAIT=2'd3); default timing constants.
//   One sub-module: sync_2ff (2-flop synchronizer, parameterised reset value), reused for future async inputs.
//   FSM, debounce counter and stretch counter stay in key_reset_conditioner.
// TESTING (bench params: pDebounceCycles=4, pResetStretch=3, pLongPressCycles=10)
//   1. iwRst=1 then deassert, iwnKey=1 -> ownSysRst=0 for 3 cycles after deassert, then 1; all strobes 0.
//   2. iwnKey 1->0 held clean -> owPress=1 exactly 6 cycles after the edge, single cycle; owKeyLevel=1; ownSysRst=0.
//   3. Key low for 3 cycles, high 1, low again (bounce) -> no owPress until 4 continuous synced-low cycles.
//   4. Release after clean press -> owRelease at +6 cycles; owKeyLevel=0; ownSysRst returns 1 three cycles after owRelease.
//   5. iwRst asserted while in PWAIT (cnt=2) -> FSM IDLE, cnt=0, no owPress; after release of iwRst, behaviour as test 1.
//   6. (KEY_LONG_PRESS_EN) hold key 30 cycles past owPress -> exactly one owLongPress, 10 cycles after entering HELD.

Source files
------------

// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
//  key_pkg
//  Shared FSM state encoding and default timing constants for the key
//  conditioner.  KEY_LONG_PRESS_EN adds the long-press default.
//  Revision: 1.0
// ============================================================================
package key_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PWAIT = 2'd1,
        HELD  = 2'd2,
        RWAIT = 2'd3
    } key_state_t;

    localparam int KEY_CNT_WIDTH       = 24;
    localparam int KEY_DEBOUNCE_CYCLES = 240000;   // 10 ms at 24 MHz
    localparam int KEY_RESET_STRETCH   = 16;

`ifdef KEY_LONG_PRESS_EN
    localparam logic [31:0] KEY_LONG_PRESS_CYCLES = 32'd48000000;  // 2 s at 24 MHz
`endif

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  sync_2ff
//  Two-flop synchronizer for a single asynchronous input, with a
//  configurable reset value.
//  Revision: 1.0
// ============================================================================
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/key_reset_conditioner.sv
`default_nettype none
// ============================================================================
//  key_reset_conditioner
//  Debounces the raw active-low key into a level, press/release strobes and a
//  stretched active-low system reset.  Define KEY_LONG_PRESS_EN to add the
//  long-press strobe output.
//  Revision: 1.0
// ============================================================================
module key_reset_conditioner
    import key_pkg::*;
#(
    parameter int                   pCntWidth        = KEY_CNT_WIDTH,
    parameter logic [pCntWidth-1:0] pDebounceCycles  = pCntWidth'(KEY_DEBOUNCE_CYCLES),
    parameter logic [pCntWidth-1:0] pResetStretch    = pCntWidth'(KEY_RESET_STRETCH)
`ifdef KEY_LONG_PRESS_EN
   ,parameter logic [31:0]          pLongPressCycles = KEY_LONG_PRESS_CYCLES
`endif
) (
    input  logic iwClk,
    input  logic iwRst,
    input  logic iwnKey,
    output logic owKeyLevel,
    output logic owPress,
    output logic owRelease,
    output logic ownSysRst
`ifdef KEY_LONG_PRESS_EN
   ,output logic owLongPress
`endif
);

    localparam logic [pCntWidth-1:0] DEB_LAST = pDebounceCycles - 1'b1;
    localparam logic [pCntWidth-1:0] CNT_ONE  = {{(pCntWidth-1){1'b0}}, 1'b1};

    key_state_t           state;
    logic [pCntWidth-1:0] cnt;
    logic [pCntWidth-1:0] cnt_inc;
    logic [pCntWidth-1:0] stretch;
    logic [pCntWidth-1:0] stretch_eff;
    logic                 boot;
    logic                 key_sync_n;
    logic                 key_sync;
    logic                 deb_done;
    logic                 enter_held;
    logic                 enter_idle;
    logic                 key_level;
    logic                 press;
    logic                 release_s;
    logic                 sys_rst_n;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_key_sync (
        .clk (iwClk),
        .rst (iwRst),
        .d   (iwnKey),
        .q   (key_sync_n)
    );

    assign key_sync    = ~key_sync_n;
    assign cnt_inc     = (cnt == '1) ? cnt : cnt + 1'b1;
    assign deb_done    = (cnt_inc >= DEB_LAST);
    assign enter_held  = (state == PWAIT) &&  key_sync && deb_done;
    assign enter_idle  = (state == RWAIT) && !key_sync && deb_done;
    // The first cycle after reset release behaves as if a full stretch was just loaded.
    assign stretch_eff = boot ? pResetStretch : stretch;

    always_ff @(posedge iwClk or posedge iwRst) begin
        if (iwRst) begin
            state     <= IDLE;
            cnt       <= '0;
            key_level <= 1'b0;
            press     <= 1'b0;
            release_s <= 1'b0;
        end else begin
            press     <= 1'b0;
            release_s <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_sync) begin
                        state <= PWAIT;
                        cnt   <= '0;
                    end
                end
                PWAIT: begin
                    if (!key_sync) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (deb_done) begin
                        state     <= HELD;
                        cnt       <= '0;
                        press     <= 1'b1;
                        key_level <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                HELD: begin
                    if (!key_sync) begin
                        state <= RWAIT;
                        cnt   <= '0;
                    end
                end
                RWAIT: begin
                    if (key_sync) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (deb_done) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        release_s <= 1'b1;
                        key_level <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge iwClk or posedge iwRst) begin
        if (iwRst) begin
            stretch   <= '0;
            boot      <= 1'b1;
            sys_rst_n <= 1'b0;
        end else if (enter_held) begin
            stretch   <= '0;
            boot      <= 1'b0;
            sys_rst_n <= 1'b0;
        end else if (state == HELD || state == RWAIT) begin
            sys_rst_n <= 1'b0;
            if (enter_idle) begin
                stretch <= pResetStretch;
            end
        end else begin
            boot <= 1'b0;
            if (stretch_eff == '0) begin
                sys_rst_n <= 1'b1;
            end else begin
                stretch   <= stretch_eff - 1'b1;
                sys_rst_n <= (stretch_eff == CNT_ONE);
            end
        end
    end

`ifdef KEY_LONG_PRESS_EN
    logic [31:0] hold;
    logic        long_press;

    // Hold count freezes during a release bounce and stops at the threshold.
    always_ff @(posedge iwClk or posedge iwRst) begin
        if (iwRst) begin
            hold       <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            if (enter_held) begin
                hold <= '0;
            end else if (state == HELD && hold < pLongPressCycles) begin
                hold       <= hold + 32'd1;
                long_press <= (hold == pLongPressCycles - 32'd1);
            end
        end
    end

    assign owLongPress = long_press;
`endif

    assign owKeyLevel = key_level;
    assign owPress    = press;
    assign owRelease  = release_s;
    assign ownSysRst  = sys_rst_n;

endmodule
`default_nettype wire

// File: tb/tb_key_reset_conditioner.sv
`default_nettype none
// ============================================================================
//  tb_key_reset_conditioner
//  Self-checking bench: cycle table for reset/press/release plus directed
//  sequences for bounce, mid-debounce reset and (optionally) long press.
//  Revision: 1.0
// ============================================================================
module tb_key_reset_conditioner;

    logic clk;
    logic rst;
    logic nkey;
    logic key_level;
    logic press;
    logic release_s;
    logic sys_rst_n;
`ifdef KEY_LONG_PRESS_EN
    logic long_press;
`endif

    int total;
    int bad;

    key_reset_conditioner #(
        .pCntWidth        (24),
        .pDebounceCycles  (24'd4),
        .pResetStretch    (24'd3)
`ifdef KEY_LONG_PRESS_EN
       ,.pLongPressCycles (32'd10)
`endif
    ) dut (
        .iwClk       (clk),
        .iwRst       (rst),
        .iwnKey      (nkey),
        .owKeyLevel  (key_level),
        .owPress     (press),
        .owRelease   (release_s),
        .ownSysRst   (sys_rst_n)
`ifdef KEY_LONG_PRESS_EN
       ,.owLongPress (long_press)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic nkey;
        logic lvl;
        logic prs;
        logic rel;
        logic srn;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int n, input logic r, input logic k,
                       input logic lvl, input logic prs, input logic rel, input logic srn);
        vec_t v;
        v.rst = r; v.nkey = k; v.lvl = lvl; v.prs = prs; v.rel = rel; v.srn = srn;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %b want %b", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic k);
        @(negedge clk);
        rst  = r;
        nkey = k;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int long_cnt;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        nkey  = 1'b1;

        // rst, nkey -> level, press, release, sys_rst_n (sampled after each edge)
        add(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // held in reset
        add(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // stretch after deassert
        add(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);   // third edge releases
        add(5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);   // sync + debounce
        add(1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);   // press 6 edges after key edge
        add(3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);   // release debounce
        add(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);   // release strobe
        add(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);   // 3 edges after release

        #1;
        check("reset_srn_async", -1, sys_rst_n, 1'b0);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].nkey);
            check("tbl_level",   i, key_level, tbl[i].lvl);
            check("tbl_press",   i, press,     tbl[i].prs);
            check("tbl_release", i, release_s, tbl[i].rel);
            check("tbl_srn",     i, sys_rst_n, tbl[i].srn);
`ifdef KEY_LONG_PRESS_EN
            check("tbl_long",    i, long_press, 1'b0);
`endif
        end

        // Bounce: 3 low, 1 high, then low; press 6 edges after the final low edge.
        for (int s = 1; s <= 12; s++) begin
            step(1'b0, (s == 4) ? 1'b1 : ((s <= 3) ? 1'b0 : 1'b0));
            if (s == 4) ;
            check("bounce_press", s, press,     (s == 10));
            check("bounce_level", s, key_level, (s >= 10));
        end
        for (int s = 1; s <= 10; s++) begin
            step(1'b0, 1'b1);
            check("bounce_release", s, release_s, (s == 6));
            check("bounce_srn",     s, sys_rst_n, (s >= 9));
        end

        // Reset during PWAIT with the debounce count at 2.
        for (int s = 1; s <= 5; s++) step(1'b0, 1'b0);
        check("pwait_state_before", 0, (dut.state == 2'd1), 1'b1);
        check("pwait_cnt_before",   0, (dut.cnt == 24'd2), 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_state", 0, (dut.state == 2'd0), 1'b1);
        check("midrst_cnt",   0, (dut.cnt == 24'd0), 1'b1);
        check("midrst_srn",   0, sys_rst_n, 1'b0);
        for (int s = 1; s <= 3; s++) begin
            step(1'b1, 1'b0);
            check("midrst_press", s, press, 1'b0);
            check("midrst_level", s, key_level, 1'b0);
        end
        for (int s = 1; s <= 5; s++) begin
            step(1'b0, 1'b1);
            check("midrst_boot_srn",   s, sys_rst_n, (s >= 3));
            check("midrst_boot_press", s, press, 1'b0);
        end

`ifdef KEY_LONG_PRESS_EN
        // Long press: press at edge 6, long strobe 10 edges later, exactly once.
        long_cnt = 0;
        for (int s = 1; s <= 36; s++) begin
            step(1'b0, 1'b0);
            if (long_press === 1'b1) long_cnt++;
            check("long_press_at", s, long_press, (s == 16));
            check("long_hold_press", s, press, (s == 6));
        end
        total++;
        if (long_cnt != 1) begin
            bad++;
            $display("FAIL long_count: got %0d want 1", long_cnt);
        end
        for (int s = 1; s <= 10; s++) begin
            step(1'b0, 1'b1);
            check("long_release", s, release_s, (s == 6));
            check("long_after",   s, long_press, 1'b0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
